// File: rtl/hawk_pixel_packer.sv
// hawk_pixel_packer: packs pairs of two-pixel beats into 64-bit words of four
// zero-extended 12-bit pixels, holds one completed word back so the final word
// of a capture can carry tlast, and buffers words in a FWFT FIFO for the writer.
//
// Output handshake: a word transfers on a cycle where m_tvalid and m_tready are
// both high; m_tvalid never waits for m_tready, and m_tdata/m_tlast stay stable
// while m_tvalid is high and m_tready is low.
module hawk_pixel_packer #(
  parameter int FIFO_DEPTH = 512,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             new_frame,
  input  logic [23:0]      pixel,
  input  logic             data_vld,
  input  logic             capture_end,
  output logic [63:0]      m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             overflow,
  output logic [31:0]      frame_words,
  output logic             frame_done,
  output logic [LVL_W-1:0] fifo_level,
  output logic [1:0]       dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_PACK   = 2'd0;
  localparam logic [1:0] ST_FLUSH1 = 2'd1;
  localparam logic [1:0] ST_FLUSH2 = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]  state, state_nxt;
  logic        half, half_nxt;
  logic [31:0] lo_q, lo_nxt;          // lanes of beat A while waiting for beat B
  logic [63:0] stg, stg_nxt;          // held-back completed word
  logic        stg_vld, stg_vld_nxt;
  logic        capture_end_q;
  logic        end_evt;
  logic [31:0] beat_lanes;

  logic        push_vld;
  logic [63:0] push_data;
  logic        push_last;
  logic        push_acc;
  logic        pop;
  logic        fifo_full;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [64:0] mem [FIFO_DEPTH];
  logic [64:0] rd_word;

  assign beat_lanes = {4'h0, pixel[23:12], 4'h0, pixel[11:0]};
  assign end_evt    = capture_end & ~capture_end_q;
  assign dbg_state  = state;

  // Packing / flush FSM: next state, staging updates and the word to push.
  always_comb begin
    state_nxt   = state;
    half_nxt    = half;
    lo_nxt      = lo_q;
    stg_nxt     = stg;
    stg_vld_nxt = stg_vld;
    push_vld    = 1'b0;
    push_data   = stg;
    push_last   = 1'b0;
    if (new_frame) begin
      // New frame discards any partial or held word and any same-cycle beat.
      state_nxt   = ST_PACK;
      half_nxt    = 1'b0;
      stg_vld_nxt = 1'b0;
    end else begin
      case (state)
        ST_PACK: begin
          if (end_evt) begin
            // An empty capture has nothing to flush and keeps packing.
            if (stg_vld || half) state_nxt = ST_FLUSH1;
          end else if (data_vld) begin
            if (!half) begin
              lo_nxt   = beat_lanes;
              half_nxt = 1'b1;
            end else begin
              // Word completes: the previous held word leaves without tlast.
              push_vld    = stg_vld;
              push_data   = stg;
              push_last   = 1'b0;
              stg_nxt     = {beat_lanes, lo_q};
              stg_vld_nxt = 1'b1;
              half_nxt    = 1'b0;
            end
          end
        end
        ST_FLUSH1: begin
          // Held word is last unless a partial word still follows it.
          push_vld    = stg_vld;
          push_data   = stg;
          push_last   = ~half;
          stg_vld_nxt = 1'b0;
          state_nxt   = half ? ST_FLUSH2 : ST_DONE;
        end
        ST_FLUSH2: begin
          push_vld  = 1'b1;
          push_data = {32'h0, lo_q};
          push_last = 1'b1;
          half_nxt  = 1'b0;
          state_nxt = ST_DONE;
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  // FSM and packing registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= ST_PACK;
      half          <= 1'b0;
      lo_q          <= '0;
      stg           <= '0;
      stg_vld       <= 1'b0;
      capture_end_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      half          <= half_nxt;
      lo_q          <= lo_nxt;
      stg           <= stg_nxt;
      stg_vld       <= stg_vld_nxt;
      capture_end_q <= capture_end;
    end
  end

  assign fifo_full  = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign pop        = m_tvalid & m_tready;
  assign push_acc   = push_vld & (~fifo_full | pop);
  assign frame_done = push_vld & push_last & ~sys_rst;

  assign m_tvalid = (fifo_level != '0);
  assign rd_word  = m_tvalid ? mem[rd_ptr] : 65'h0;
  assign m_tdata  = rd_word[63:0];
  assign m_tlast  = rd_word[64];

  // FIFO storage; contents need no reset because reads are masked when empty.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst && push_acc) mem[wr_ptr] <= {push_last, push_data};
  end

  // FIFO pointers, occupancy and per-frame statistics.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      overflow    <= 1'b0;
      frame_words <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      case ({push_acc, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (new_frame) begin
        overflow    <= 1'b0;
        frame_words <= '0;
      end else begin
        if (push_vld && !push_acc) overflow <= 1'b1;
        if (push_acc) frame_words <= frame_words + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hawk_pixel_packer.sv
// Bench for hawk_pixel_packer: a 512-deep instance checked against a
// frame-level model, plus a 4-deep instance sharing the same stimulus for
// the overflow scenario.
module tb_hawk_pixel_packer;

  logic        sys_clk = 1'b0;
  logic        sys_rst, new_frame, data_vld, capture_end, m_tready;
  logic [23:0] pixel;

  logic [63:0] m_tdata;
  logic        m_tvalid, m_tlast, overflow, frame_done;
  logic [31:0] frame_words;
  logic [9:0]  fifo_level;
  logic [1:0]  dbg_state;

  logic [63:0] s_tdata;
  logic        s_tvalid, s_tlast, s_overflow, s_frame_done;
  logic [31:0] s_frame_words;
  logic [2:0]  s_fifo_level;
  logic [1:0]  s_dbg_state;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  bit          rand_ready = 0;
  bit          frame_open = 0;
  logic [64:0] exp_q[$];
  logic [64:0] got_q[$];
  logic [23:0] beats[$];

  hawk_pixel_packer dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .new_frame(new_frame), .pixel(pixel),
    .data_vld(data_vld), .capture_end(capture_end), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .overflow(overflow), .frame_words(frame_words), .frame_done(frame_done),
    .fifo_level(fifo_level), .dbg_state(dbg_state)
  );

  hawk_pixel_packer #(.FIFO_DEPTH(4)) dut_small (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .new_frame(new_frame), .pixel(pixel),
    .data_vld(data_vld), .capture_end(capture_end), .m_tdata(s_tdata),
    .m_tvalid(s_tvalid), .m_tready(m_tready), .m_tlast(s_tlast),
    .overflow(s_overflow), .frame_words(s_frame_words), .frame_done(s_frame_done),
    .fifo_level(s_fifo_level), .dbg_state(s_dbg_state)
  );

  // Clock
  always #5 sys_clk = ~sys_clk;

  // Monitor: record every transferred word and every frame_done pulse.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
      if (frame_done) done_cnt++;
    end
  end

  // Reference model: four zero-extended pixels per word, beat A in the low half.
  function automatic logic [63:0] pack_word(input logic [23:0] a, input logic [23:0] b);
    return {4'h0, b[23:12], 4'h0, b[11:0], 4'h0, a[23:12], 4'h0, a[11:0]};
  endfunction

  // Closing a frame: a completed capture yields every word (partial one
  // zero-padded) with tlast on the last; an aborted frame loses its
  // partial word and its newest complete word, and carries no tlast.
  task automatic model_close(input bit completed);
    int n, nw;
    logic [23:0] lo, hi;
    n = beats.size();
    if (completed) begin
      nw = (n + 1) / 2;
      for (int i = 0; i < nw; i++) begin
        lo = beats[2*i];
        hi = (2*i + 1 < n) ? beats[2*i + 1] : 24'h0;
        exp_q.push_back({(i == nw - 1) ? 1'b1 : 1'b0, pack_word(lo, hi)});
      end
      if (nw > 0) exp_done++;
    end else begin
      nw = n / 2;
      for (int i = 0; i < nw - 1; i++)
        exp_q.push_back({1'b0, pack_word(beats[2*i], beats[2*i + 1])});
    end
    beats.delete();
    frame_open = 0;
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (rand_ready) m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; new_frame = 1'b0; data_vld = 1'b0; capture_end = 1'b0;
    repeat (2) tick();
    sys_rst = 1'b0;
    exp_q.delete(); got_q.delete(); beats.delete();
    frame_open = 0; done_cnt = 0; exp_done = 0;
  endtask

  task automatic start_frame(input bit with_beat);
    if (frame_open) model_close(0);
    new_frame = 1'b1; capture_end = 1'b0;
    data_vld = with_beat; pixel = 24'($urandom);
    tick();
    new_frame = 1'b0; data_vld = 1'b0;
    frame_open = 1;
  endtask

  task automatic send_beat(input logic [23:0] p);
    data_vld = 1'b1; pixel = p;
    beats.push_back(p);
    tick();
    data_vld = 1'b0;
  endtask

  // One idle cycle after the last beat, then capture_end rises and stays high.
  task automatic end_capture();
    tick();
    capture_end = 1'b1;
    model_close(1);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge sys_clk);
    checks++; if (m_tdata !== 64'h0) begin errors++; $display("FAIL reset_tdata got %h exp 0", m_tdata); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", m_tvalid); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b exp 0", m_tlast); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    checks++; if (frame_words !== 32'd0) begin errors++; $display("FAIL reset_frame_words got %0d exp 0", frame_words); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    checks++; if (fifo_level !== 10'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
  endtask

  task automatic test_basic();
    m_tready = 1'b1; done_cnt = 0; exp_done = 0;
    start_frame(0);
    for (int k = 0; k < 8; k++) begin
      send_beat({12'(2*k + 1), 12'(2*k)});
      if (k == 2) begin
        @(negedge sys_clk);
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL basic_tvalid_early got %b exp 0", m_tvalid); end
      end
      if (k == 3) begin
        @(negedge sys_clk);
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL basic_tvalid_latency got %b exp 1", m_tvalid); end
      end
    end
    end_capture();
    tick();
    @(negedge sys_clk);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL basic_done_timing got %b exp 1", frame_done); end
    repeat (8) tick();
    @(negedge sys_clk);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== {1'b0, 64'h0003_0002_0001_0000}) begin errors++; $display("FAIL basic_word0_const got %h exp 0_0003000200010000", got_q[0]); end
    end
    checks++; if (frame_words !== 32'd4) begin errors++; $display("FAIL basic_frame_words got %0d exp 4", frame_words); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", done_cnt); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_odd();
    m_tready = 1'b1; done_cnt = 0; exp_done = 0;
    start_frame(0);
    for (int k = 0; k < 5; k++) send_beat(24'($urandom));
    end_capture();
    tick();
    @(negedge sys_clk);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL odd_done_early got %b exp 0", frame_done); end
    tick();
    @(negedge sys_clk);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL odd_done_timing got %b exp 1", frame_done); end
    repeat (8) tick();
    @(negedge sys_clk);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL odd_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL odd_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() == 3) begin
      checks++; if (got_q[2][63:32] !== 32'h0) begin errors++; $display("FAIL odd_upper got %h exp 0", got_q[2][63:32]); end
      checks++; if (got_q[2][64] !== 1'b1) begin errors++; $display("FAIL odd_last2 got %b exp 1", got_q[2][64]); end
      checks++; if (got_q[1][64] !== 1'b0) begin errors++; $display("FAIL odd_last1 got %b exp 0", got_q[1][64]); end
    end
    checks++; if (frame_words !== 32'd3) begin errors++; $display("FAIL odd_frame_words got %0d exp 3", frame_words); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    logic [63:0] hold;
    m_tready = 1'b0; done_cnt = 0; exp_done = 0;
    start_frame(0);
    for (int k = 0; k < 16; k++) send_beat(24'($urandom));
    end_capture();
    repeat (4) tick();
    @(negedge sys_clk);
    checks++; if (fifo_level !== 10'd8) begin errors++; $display("FAIL bp_level got %0d exp 8", fifo_level); end
    hold = m_tdata;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge sys_clk);
      checks++; if (m_tdata !== hold || m_tvalid !== 1'b1) begin errors++; $display("FAIL bp_stable got %h/%b exp %h/1", m_tdata, m_tvalid, hold); end
    end
    tick();
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL bp_drain%0d got %b exp 1", i, m_tvalid); end
      tick();
    end
    @(negedge sys_clk);
    checks++; if (fifo_level !== 10'd0) begin errors++; $display("FAIL bp_empty got %0d exp 0", fifo_level); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_overflow();
    do_reset();
    m_tready = 1'b0;
    start_frame(0);
    for (int k = 0; k < 12; k++) send_beat(24'($urandom));
    repeat (3) tick();
    @(negedge sys_clk);
    checks++; if (s_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", s_overflow); end
    checks++; if (s_frame_words !== 32'd4) begin errors++; $display("FAIL ovf_frame_words got %0d exp 4", s_frame_words); end
    checks++; if (s_fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", s_fifo_level); end
    checks++; if (overflow !== 1'b0 || fifo_level !== 10'd5) begin errors++; $display("FAIL ovf_big got %b/%0d exp 0/5", overflow, fifo_level); end
    start_frame(0);
    @(negedge sys_clk);
    checks++; if (s_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", s_overflow); end
    checks++; if (s_frame_words !== 32'd0) begin errors++; $display("FAIL ovf_words_clear got %0d exp 0", s_frame_words); end
    checks++; if (s_fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level_kept got %0d exp 4", s_fifo_level); end
    m_tready = 1'b1;
    repeat (8) tick();
    @(negedge sys_clk);
    checks++; if (s_fifo_level !== 3'd0) begin errors++; $display("FAIL ovf_drained got %0d exp 0", s_fifo_level); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_abort();
    m_tready = 1'b1; done_cnt = 0; exp_done = 0;
    start_frame(0);
    for (int k = 0; k < 3; k++) send_beat(24'($urandom));
    start_frame(1);
    for (int k = 0; k < 4; k++) send_beat(24'($urandom));
    end_capture();
    repeat (6) tick();
    @(negedge sys_clk);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (frame_words !== 32'd2) begin errors++; $display("FAIL abort_frame_words got %0d exp 2", frame_words); end
    checks++; if (done_cnt !== exp_done) begin errors++; $display("FAIL abort_done got %0d exp %0d", done_cnt, exp_done); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_flush();
    m_tready = 1'b0;
    start_frame(0);
    for (int k = 0; k < 6; k++) send_beat(24'($urandom));
    end_capture();
    tick();
    sys_rst = 1'b1; capture_end = 1'b0;
    tick();
    sys_rst = 1'b0;
    exp_q.delete(); got_q.delete(); beats.delete(); frame_open = 0;
    @(negedge sys_clk);
    checks++; if (m_tvalid !== 1'b0 || fifo_level !== 10'd0) begin errors++; $display("FAIL rstf_fifo got %b/%0d exp 0/0", m_tvalid, fifo_level); end
    checks++; if (m_tdata !== 64'h0 || m_tlast !== 1'b0) begin errors++; $display("FAIL rstf_data got %h/%b exp 0/0", m_tdata, m_tlast); end
    checks++; if (frame_words !== 32'd0 || overflow !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL rstf_stats got %0d/%b/%b exp 0/0/0", frame_words, overflow, frame_done); end
    m_tready = 1'b1;
    repeat (6) tick();
    @(negedge sys_clk);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rstf_no_words got %0d exp 0", got_q.size()); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    int n;
    done_cnt = 0; exp_done = 0; rand_ready = 1;
    for (int f = 0; f < 8; f++) begin
      start_frame(1'($urandom_range(0, 1)));
      n = $urandom_range(0, 9);
      for (int j = 0; j < n; j++) begin
        send_beat(24'($urandom));
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
      end
      if ($urandom_range(0, 3) != 0) begin
        end_capture();
        repeat (3) tick();
      end
    end
    start_frame(0);
    rand_ready = 0; m_tready = 1'b1;
    repeat (30) tick();
    @(negedge sys_clk);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt !== exp_done) begin errors++; $display("FAIL rand_done got %0d exp %0d", done_cnt, exp_done); end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    sys_rst = 1'b1; new_frame = 1'b0; data_vld = 1'b0; capture_end = 1'b0;
    m_tready = 1'b0; pixel = 24'h0;
    test_reset();
    test_basic();
    test_odd();
    test_backpressure();
    test_overflow();
    test_abort();
    test_reset_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
